// File: rtl/mem_conflict_serializer_if.sv
// Pipeline/memory bundle around the conflict serializer.
// slave = serializer side, master = pipeline + memory environment side.
interface mem_conflict_serializer_if #(
    parameter int CNT_W = 16
);
    logic              ValidM1, ValidM2;
    logic              MemWriteM1, MemWriteM2;
    logic              MemReadM1, MemReadM2;
    logic [31:0]       ALUResultM1, ALUResultM2;
    logic [31:0]       WriteDataM1, WriteDataM2;
    logic [2:0]        AddressingControlM1, AddressingControlM2;
    logic [31:0]       RD1, RD2;
    logic [31:0]       A1, A2;
    logic              WE1, WE2;
    logic [31:0]       WD1, WD2;
    logic [2:0]        AC1, AC2;
    logic [31:0]       ReadDataM1, ReadDataM2;
    logic              StallMem;
    logic [CNT_W-1:0]  ConflictCount;

    modport slave (
        input  ValidM1, ValidM2, MemWriteM1, MemWriteM2, MemReadM1, MemReadM2,
        input  ALUResultM1, ALUResultM2, WriteDataM1, WriteDataM2,
        input  AddressingControlM1, AddressingControlM2, RD1, RD2,
        output A1, A2, WE1, WE2, WD1, WD2, AC1, AC2,
        output ReadDataM1, ReadDataM2, StallMem, ConflictCount
    );

    modport master (
        output ValidM1, ValidM2, MemWriteM1, MemWriteM2, MemReadM1, MemReadM2,
        output ALUResultM1, ALUResultM2, WriteDataM1, WriteDataM2,
        output AddressingControlM1, AddressingControlM2, RD1, RD2,
        input  A1, A2, WE1, WE2, WD1, WD2, AC1, AC2,
        input  ReadDataM1, ReadDataM2, StallMem, ConflictCount
    );
endinterface

// File: rtl/mem_conflict_serializer.sv
// Splits same-word dual-lane memory conflicts into two ordered cycles (lane 1 first),
// stalling the pipeline for one cycle and holding lane-1 load data; counts splits.
module mem_conflict_serializer #(
    parameter int CMP_LSB = 2,
    parameter int CNT_W   = 16
) (
    input logic                   clk,
    input logic                   rst,
    mem_conflict_serializer_if.slave bus
);
    typedef enum logic {PASS, SPLIT} state_t;

    state_t           state;
    logic [31:0]      hold;
    logic [CNT_W-1:0] cnt;
    logic             acc1, acc2, conflict;
    logic             we1g, we2g;
    logic             we1, we2, stall;
    logic [31:0]      rdata1, rdata2;

    always_comb begin
        acc1     = bus.ValidM1 & (bus.MemWriteM1 | bus.MemReadM1);
        acc2     = bus.ValidM2 & (bus.MemWriteM2 | bus.MemReadM2);
        conflict = acc1 & acc2 & (bus.MemWriteM1 | bus.MemWriteM2) &
                   (bus.ALUResultM1[31:CMP_LSB] == bus.ALUResultM2[31:CMP_LSB]);
        we1g     = bus.MemWriteM1 & bus.ValidM1;
        we2g     = bus.MemWriteM2 & bus.ValidM2;
    end

    always_comb begin
        we1    = we1g;
        we2    = we2g;
        stall  = 1'b0;
        rdata1 = bus.RD1;
        rdata2 = bus.RD2;
        if (rst) begin
            // Reset overrides both states, so a reset in SPLIT aborts lane 2.
            we1 = 1'b0;
            we2 = 1'b0;
        end else if (state == SPLIT) begin
            we1    = 1'b0;
            rdata1 = hold;
        end else if (conflict) begin
            we2   = 1'b0;
            stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PASS;
            hold  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                PASS: begin
                    if (conflict) begin
                        state <= SPLIT;
                        hold  <= bus.RD1;
                        if (cnt != '1)
                            cnt <= cnt + CNT_W'(1);
                    end
                end
                SPLIT:   state <= PASS;
                default: state <= PASS;
            endcase
        end
    end

    assign bus.A1            = bus.ALUResultM1;
    assign bus.A2            = bus.ALUResultM2;
    assign bus.WD1           = bus.WriteDataM1;
    assign bus.WD2           = bus.WriteDataM2;
    assign bus.AC1           = bus.AddressingControlM1;
    assign bus.AC2           = bus.AddressingControlM2;
    assign bus.WE1           = we1;
    assign bus.WE2           = we2;
    assign bus.StallMem      = stall;
    assign bus.ReadDataM1    = rdata1;
    assign bus.ReadDataM2    = rdata2;
    assign bus.ConflictCount = cnt;
endmodule

// File: tb/tb_mem_conflict_serializer.sv
// Randomized + directed bench for mem_conflict_serializer against a program-order memory model.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_mem_conflict_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_conflict_serializer_if #(.CNT_W(16)) bus ();
    mem_conflict_serializer_if #(.CNT_W(2))  bus2 ();

    mem_conflict_serializer #(.CMP_LSB(2), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    mem_conflict_serializer #(.CMP_LSB(2), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cnt_model = 0;
    int unsigned cnt2_model = 0;

    logic [31:0] mem  [0:1023];
    logic [31:0] refm [0:1023];

    // AC[1:0]: 0 = byte, 1 = half, otherwise word; reads return the full word.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [31:0] d, input logic [2:0] ac);
        logic [31:0] r;
        r = old;
        case (ac[1:0])
            2'd0:    r[a[1:0]*8 +: 8]  = d[7:0];
            2'd1:    r[a[1]*16 +: 16]  = d[15:0];
            default: r                 = d;
        endcase
        return r;
    endfunction

    assign bus.RD1  = mem[bus.A1[11:2]];
    assign bus.RD2  = mem[bus.A2[11:2]];
    assign bus2.RD1 = mem[bus2.A1[11:2]];
    assign bus2.RD2 = mem[bus2.A2[11:2]];

    always @(posedge clk) begin
        if (bus.WE1) mem[bus.A1[11:2]] <= merge(mem[bus.A1[11:2]], bus.A1, bus.WD1, bus.AC1);
        if (bus.WE2) mem[bus.A2[11:2]] <= merge(mem[bus.A2[11:2]], bus.A2, bus.WD2, bus.AC2);
    end

    assign bus2.ValidM1 = bus.ValidM1;
    assign bus2.ValidM2 = bus.ValidM2;
    assign bus2.MemWriteM1 = bus.MemWriteM1;
    assign bus2.MemWriteM2 = bus.MemWriteM2;
    assign bus2.MemReadM1 = bus.MemReadM1;
    assign bus2.MemReadM2 = bus.MemReadM2;
    assign bus2.ALUResultM1 = bus.ALUResultM1;
    assign bus2.ALUResultM2 = bus.ALUResultM2;
    assign bus2.WriteDataM1 = bus.WriteDataM1;
    assign bus2.WriteDataM2 = bus.WriteDataM2;
    assign bus2.AddressingControlM1 = bus.AddressingControlM1;
    assign bus2.AddressingControlM2 = bus.AddressingControlM2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v1, w1, r1, input logic [31:0] a1, d1, input logic [2:0] c1,
                         input logic v2, w2, r2, input logic [31:0] a2, d2, input logic [2:0] c2);
        bus.ValidM1 = v1; bus.MemWriteM1 = w1; bus.MemReadM1 = r1;
        bus.ALUResultM1 = a1; bus.WriteDataM1 = d1; bus.AddressingControlM1 = c1;
        bus.ValidM2 = v2; bus.MemWriteM2 = w2; bus.MemReadM2 = r2;
        bus.ALUResultM2 = a2; bus.WriteDataM2 = d2; bus.AddressingControlM2 = c2;
    endtask

    // One instruction pair; called #1 after a rising edge, returns #1 after its last edge.
    task automatic txn(input logic v1, w1, r1, input logic [31:0] a1, d1, input logic [2:0] c1,
                       input logic v2, w2, r2, input logic [31:0] a2, d2, input logic [2:0] c2,
                       output logic [31:0] o1, output logic [31:0] o2);
        logic acc1, acc2, conf;
        logic [31:0] e1, e2;
        drive(v1, w1, r1, a1, d1, c1, v2, w2, r2, a2, d2, c2);
        acc1 = v1 && (w1 || r1);
        acc2 = v2 && (w2 || r2);
        conf = acc1 && acc2 && (w1 || w2) && (a1[31:2] == a2[31:2]);
        // Sequential semantics: lane 1 completes before lane 2 observes memory.
        e1 = refm[a1[11:2]];
        if (v1 && w1) refm[a1[11:2]] = merge(refm[a1[11:2]], a1, d1, c1);
        e2 = refm[a2[11:2]];
        if (v2 && w2) refm[a2[11:2]] = merge(refm[a2[11:2]], a2, d2, c2);
        @(negedge clk);
        check("stall", {31'b0, bus.StallMem}, {31'b0, conf});
        check("we1", {31'b0, bus.WE1}, {31'b0, v1 & w1});
        check("a1", bus.A1, a1);
        check("wd2", bus.WD2, d2);
        if (conf) begin
            check("we2_pass", {31'b0, bus.WE2}, 32'd0);
            cnt_model  = (cnt_model  < 65535) ? cnt_model  + 1 : cnt_model;
            cnt2_model = (cnt2_model < 3)     ? cnt2_model + 1 : cnt2_model;
            @(posedge clk);
            @(negedge clk);
            check("stall_split", {31'b0, bus.StallMem}, 32'd0);
            check("we1_split", {31'b0, bus.WE1}, 32'd0);
            check("we2_split", {31'b0, bus.WE2}, {31'b0, v2 & w2});
            check("a2_split", bus.A2, a2);
        end else begin
            check("we2", {31'b0, bus.WE2}, {31'b0, v2 & w2});
            check("a2", bus.A2, a2);
        end
        o1 = bus.ReadDataM1;
        o2 = bus.ReadDataM2;
        if (acc1 && r1) check("rdata1", o1, e1);
        if (acc2 && r2) check("rdata2", o2, e2);
        @(posedge clk);
        #1;
        check("count", 32'(bus.ConflictCount), cnt_model);
        check("count2", 32'(bus2.ConflictCount), cnt2_model);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd2);
    endtask

    initial begin
        logic [31:0] o1, o2;
        logic        v1, w1, r1, v2, w2, r2;
        logic [31:0] a1, a2, d1, d2;
        logic [2:0]  c1, c2;
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 32'h0;
            refm[i] = 32'h0;
        end

        // Stores presented during reset must not reach memory.
        drive(1'b1, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFFF, 3'd2,
              1'b1, 1'b1, 1'b0, 32'h100, 32'hEEEE_EEEE, 3'd2);
        @(negedge clk);
        check("rst_we1", {31'b0, bus.WE1}, 32'd0);
        check("rst_we2", {31'b0, bus.WE2}, 32'd0);
        check("rst_stall", {31'b0, bus.StallMem}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_count", 32'(bus.ConflictCount), 32'd0);
        check("rst_mem", mem[32'h100 >> 2], 32'h0);
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // No conflict: store 0x100, load 0x104, then reload 0x100.
        txn(1, 1, 0, 32'h100, 32'hDEADBEEF, 3'd2, 1, 0, 1, 32'h104, 32'h0, 3'd2, o1, o2);
        txn(1, 0, 1, 32'h100, 32'h0, 3'd2, 0, 0, 0, 32'h0, 32'h0, 3'd2, o1, o2);
        check("noconf_reload", o1, 32'hDEADBEEF);

        // Store-then-load, same word.
        txn(1, 1, 0, 32'h200, 32'h12345678, 3'd2, 1, 0, 1, 32'h200, 32'h0, 3'd2, o1, o2);
        check("st_ld_rd2", o2, 32'h12345678);
        check("st_ld_cnt", 32'(bus.ConflictCount), 32'd1);

        // Load-then-store: lane 1 sees old word, byte lands afterwards.
        txn(1, 1, 0, 32'h300, 32'hAAAA5555, 3'd2, 0, 0, 0, 32'h0, 32'h0, 3'd2, o1, o2);
        txn(1, 0, 1, 32'h300, 32'h0, 3'd2, 1, 1, 0, 32'h301, 32'h000000FF, 3'd0, o1, o2);
        check("ld_st_rd1", o1, 32'hAAAA5555);
        check("ld_st_mem", mem[32'h300 >> 2], 32'hAAAAFF55);

        // Store-store: lane 2 wins.
        txn(1, 1, 0, 32'h400, 32'd1, 3'd2, 1, 1, 0, 32'h400, 32'd2, 3'd2, o1, o2);
        check("st_st_mem", mem[32'h400 >> 2], 32'd2);

        // Non-conflicting pairs: two loads, and an invalid lane 2 store.
        txn(1, 0, 1, 32'h400, 32'h0, 3'd2, 1, 0, 1, 32'h402, 32'h0, 3'd2, o1, o2);
        txn(1, 1, 0, 32'h400, 32'd7, 3'd2, 0, 1, 0, 32'h400, 32'd9, 3'd2, o1, o2);
        check("inval_mem", mem[32'h400 >> 2], 32'd7);

        // Back-to-back conflicts.
        txn(1, 1, 0, 32'h200, 32'h1, 3'd2, 1, 0, 1, 32'h200, 32'h0, 3'd2, o1, o2);
        txn(1, 0, 1, 32'h200, 32'h0, 3'd2, 1, 1, 0, 32'h200, 32'h5, 3'd2, o1, o2);
        check("sat_cnt2", 32'(bus2.ConflictCount), 32'd3);

        // Reset asserted in SPLIT aborts the pending lane-2 store.
        drive(1'b1, 1'b1, 1'b0, 32'h108, 32'h11, 3'd2, 1'b1, 1'b1, 1'b0, 32'h108, 32'h22, 3'd2);
        @(negedge clk);
        check("rsplit_stall", {31'b0, bus.StallMem}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rsplit_we2", {31'b0, bus.WE2}, 32'd0);
        check("rsplit_stall2", {31'b0, bus.StallMem}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        refm[32'h108 >> 2] = 32'h11;
        cnt_model  = 0;
        cnt2_model = 0;
        check("rsplit_cnt", 32'(bus.ConflictCount), 32'd0);
        check("rsplit_mem", mem[32'h108 >> 2], 32'h11);
        txn(1, 0, 1, 32'h108, 32'h0, 3'd2, 0, 0, 0, 32'h0, 32'h0, 3'd2, o1, o2);

        // Randomized pairs over a small window of words to provoke conflicts.
        for (int n = 0; n < 300; n++) begin
            v1 = ($urandom_range(0, 7) != 0);
            v2 = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 2))
                0: begin w1 = 0; r1 = 0; end
                1: begin w1 = 0; r1 = 1; end
                default: begin w1 = 1; r1 = 0; end
            endcase
            case ($urandom_range(0, 2))
                0: begin w2 = 0; r2 = 0; end
                1: begin w2 = 0; r2 = 1; end
                default: begin w2 = 1; r2 = 0; end
            endcase
            c1 = 3'($urandom_range(0, 2));
            c2 = 3'($urandom_range(0, 2));
            a1 = 32'h100 + ($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
            a2 = 32'h100 + ($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
            d1 = $urandom;
            d2 = $urandom;
            txn(v1, w1, r1, a1, d1, c1, v2, w2, r2, a2, d2, c2, o1, o2);
        end
        idle();
        for (int i = 32'h100 >> 2; i < (32'h110 >> 2); i++)
            check("final_mem", mem[i], refm[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
